// File: rtl/trace_buffer.sv
// -----------------------------------------------------------------------------
// trace_buffer
//
// Elastic FIFO stage behind the EX tracker. Every element presented on an
// ex_data_ready strobe is captured and held until the trace sink drains it
// over a valid/ready handshake. The tracker is never back-pressured: elements
// arriving while the buffer is full are dropped, counted (saturating) and
// flagged with a sticky overflow bit.
//
// Parameters
//   DEPTH       number of stored elements (power of two, >= 2)
//   CNT_WIDTH   width of the drop counter
//   DATA_WIDTH  element width; instantiate with $bits(ryuki_datatypes::trace_output)
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous, active-high reset
//   ex_data_ready  one-cycle strobe, ex_data_in valid this cycle
//   ex_data_in     trace element, stored opaquely
//   trace_data_o   head element (show-ahead)
//   trace_valid_o  head element is valid
//   trace_ready_i  sink accepts the head this cycle
//   level_o        occupancy, 0..DEPTH
//   full_o         level_o == DEPTH
//   empty_o        level_o == 0
//   overflow_o     sticky: at least one element dropped since reset/clear
//   drop_count_o   saturating count of dropped elements
//   clear_i        synchronous clear of overflow_o and drop_count_o
// -----------------------------------------------------------------------------
module trace_buffer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ex_data_ready,
  input  logic [DATA_WIDTH-1:0]        ex_data_in,
  output logic [DATA_WIDTH-1:0]        trace_data_o,
  output logic                         trace_valid_o,
  input  logic                         trace_ready_i,
  output logic [$clog2(DEPTH):0]       level_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         overflow_o,
  output logic [CNT_WIDTH-1:0]         drop_count_o,
  input  logic                         clear_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;

  logic full, empty, pop, push, drop;

  // Flags come straight from the count register, so full and empty are
  // never ambiguous even when the pointers are equal.
  assign full  = (count_q == LVL_W'(DEPTH));
  assign empty = (count_q == '0);

  assign pop  = !empty && trace_ready_i;
  // A strobe into a full buffer still lands if the head leaves this cycle.
  assign push = ex_data_ready && (!full || pop);
  assign drop = ex_data_ready && full && !pop;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    // Pointers are exactly PTR_W bits wide, so DEPTH-1 + 1 wraps to 0.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase

    // A drop coinciding with a clear must survive the clear so that the
    // loss is never hidden from software.
    if (clear_i) begin
      overflow_d   = drop;
      drop_count_d = drop ? CNT_WIDTH'(1) : '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (!(&drop_count_q)) drop_count_d = drop_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of statement order.
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // NOTE: the storage array has no reset; stale contents are unreachable
  // because the pointers and count are reset, and leaving it unreset lets it
  // map onto plain RAM. The write is still blocked during reset so a strobe
  // in that cycle leaves no trace.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= ex_data_in;
  end

  assign trace_data_o  = mem_q[rd_ptr_q];
  assign trace_valid_o = !empty;
  assign level_o       = count_q;
  assign full_o        = full;
  assign empty_o       = empty;
  assign overflow_o    = overflow_q;
  assign drop_count_o  = drop_count_q;

endmodule

// File: tb/tb_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_trace_buffer
//
// Self-checking bench for trace_buffer (DEPTH=4, CNT_WIDTH=4, 16-bit data).
// A queue-based reference model tracks the stored elements, the drop count
// and the overflow flag; every cycle all DUT outputs are compared against it.
// Directed sequences cover reset, ordering/wrap, overflow, full push+pop,
// clear, saturation and streaming; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_trace_buffer;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int DW      = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ex_data_ready;
  logic [DW-1:0]        ex_data_in;
  logic [DW-1:0]        trace_data_o;
  logic                 trace_valid_o;
  logic                 trace_ready_i;
  logic [$clog2(DEPTH):0] level_o;
  logic                 full_o;
  logic                 empty_o;
  logic                 overflow_o;
  logic [CNT_W-1:0]     drop_count_o;
  logic                 clear_i;

  trace_buffer #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_W), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_data_ready (ex_data_ready),
    .ex_data_in    (ex_data_in),
    .trace_data_o  (trace_data_o),
    .trace_valid_o (trace_valid_o),
    .trace_ready_i (trace_ready_i),
    .level_o       (level_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .overflow_o    (overflow_o),
    .drop_count_o  (drop_count_o),
    .clear_i       (clear_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [DW-1:0] mq[$];
  int            m_drops = 0;
  bit            m_ov    = 1'b0;
  bit            m_ok    = 1'b0;  // set once the model knows the DUT state
  int            stream_pops;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, compare outputs with
  // the model, then advance the model at the rising edge.
  task automatic cycle(input bit r, input bit s, input logic [DW-1:0] d,
                       input bit rd, input bit clr);
    bit m_full, m_pop, m_push, m_drop;
    @(negedge clk);
    rst = r; ex_data_ready = s; ex_data_in = d; trace_ready_i = rd; clear_i = clr;
    #1;
    if (m_ok) begin
      check("valid", 32'(trace_valid_o), 32'(mq.size() != 0));
      check("level", 32'(level_o), 32'(mq.size()));
      check("full", 32'(full_o), 32'(mq.size() == DEPTH));
      check("empty", 32'(empty_o), 32'(mq.size() == 0));
      check("overflow", 32'(overflow_o), 32'(m_ov));
      check("drop_count", 32'(drop_count_o), 32'(m_drops));
      if (mq.size() != 0) check("head_data", 32'(trace_data_o), 32'(mq[0]));
    end
    @(posedge clk);
    m_full = (mq.size() == DEPTH);
    m_pop  = (mq.size() != 0) && rd;
    m_push = s && (!m_full || m_pop);
    m_drop = s && m_full && !m_pop;
    if (rd && m_pop) stream_pops++;
    if (r) begin
      mq.delete();
      m_drops = 0;
      m_ov    = 1'b0;
      m_ok    = 1'b1;
    end else begin
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(d);
      if (clr) begin
        m_drops = m_drop ? 1 : 0;
        m_ov    = m_drop;
      end else if (m_drop) begin
        m_ov = 1'b1;
        if (m_drops < CNT_MAX) m_drops++;
      end
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input bit rd);
    cycle(1'b0, 1'b1, d, rd, 1'b0);
  endtask

  task automatic idle(input bit rd);
    cycle(1'b0, 1'b0, '0, rd, 1'b0);
  endtask

  initial begin
    rst = 1'b0; ex_data_ready = 1'b0; ex_data_in = '0;
    trace_ready_i = 1'b0; clear_i = 1'b0;

    // 1. Reset for two cycles with strobes active: nothing stored.
    cycle(1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0);
    #1;
    check("rst_level", 32'(level_o), 0);
    check("rst_empty", 32'(empty_o), 1);
    check("rst_valid", 32'(trace_valid_o), 0);
    check("rst_drops", 32'(drop_count_o), 0);
    idle(1'b1);
    #1;
    check("rst_nothing_stored", 32'(level_o), 0);

    // 2. Ordering and wrap.
    push(16'h00A0, 1'b0); push(16'h00B0, 1'b0);
    push(16'h00C0, 1'b0); push(16'h00D0, 1'b0);
    #1;
    check("ord_full", 32'(full_o), 1);
    check("ord_level", 32'(level_o), 4);
    idle(1'b1); idle(1'b1);
    push(16'h00E0, 1'b0); push(16'h00F0, 1'b0);
    repeat (4) idle(1'b1);
    #1;
    check("ord_empty_end", 32'(empty_o), 1);

    // 3. Overflow: fill then strobe three more times without popping.
    push(16'h0A0A, 1'b0); push(16'h0B0B, 1'b0);
    push(16'h0C0C, 1'b0); push(16'h0D0D, 1'b0);
    push(16'h0E01, 1'b0); push(16'h0E02, 1'b0); push(16'h0E03, 1'b0);
    #1;
    check("ovf_drops", 32'(drop_count_o), 3);
    check("ovf_flag", 32'(overflow_o), 1);
    check("ovf_head", 32'(trace_data_o), 32'h0A0A);

    // 4. Full with ready: G accepted, level stays at 4, no new drop.
    push(16'h0606, 1'b1);
    #1;
    check("fpp_level", 32'(level_o), 4);
    check("fpp_drops", 32'(drop_count_o), 3);
    repeat (3) idle(1'b0);
    repeat (4) idle(1'b1);   // B, C, D, then G last
    #1;
    check("fpp_empty", 32'(empty_o), 1);

    // 5. Clear alone, then clear coinciding with a drop.
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    #1;
    check("clr_drops", 32'(drop_count_o), 0);
    check("clr_flag", 32'(overflow_o), 0);
    for (int i = 0; i < DEPTH; i++) push(16'h5000 + 16'(i), 1'b0);
    cycle(1'b0, 1'b1, 16'h5FFF, 1'b0, 1'b1);
    #1;
    check("clrdrop_drops", 32'(drop_count_o), 1);
    check("clrdrop_flag", 32'(overflow_o), 1);

    // 6a. Saturation: 20 drops on a 4-bit counter.
    for (int i = 0; i < 20; i++) push(16'h6000 + 16'(i), 1'b0);
    #1;
    check("sat_drops", 32'(drop_count_o), 15);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    repeat (DEPTH) idle(1'b1);

    // 6b. Streaming one element per cycle with ready held high.
    stream_pops = 0;
    for (int i = 0; i < 100; i++) push(16'h7000 + 16'(i), 1'b1);
    idle(1'b1);
    #1;
    check("stream_drops", 32'(drop_count_o), 0);
    check("stream_pops", 32'(stream_pops), 100);
    check("stream_empty", 32'(empty_o), 1);

    // Randomized phase, two ready biases so both full and empty are visited.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        cycle(($urandom_range(99) == 0),
              ($urandom_range(9) < 6),
              16'($urandom),
              (ph == 0) ? ($urandom_range(9) < 3) : ($urandom_range(9) < 8),
              ($urandom_range(19) == 0));
      end
    end
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_buffer.md
# trace_buffer

Elastic FIFO stage directly downstream of the EX tracker in the trace unit. It captures every completed `trace_output` element the EX tracker presents on its `ex_data_ready` pulse and holds it until the trace sink drains it over a valid/ready handshake. It absorbs bursts from the pipeline trackers without back-pressuring them. Elements that arrive while the buffer is full are dropped and counted, and a sticky flag reports the loss.

## Interface
Parameters:
- `DEPTH`, 16, number of stored elements; power of two, ≥ 2.
- `CNT_WIDTH`, 16, width of the drop counter.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `ex_data_ready` input 1: one-cycle strobe from the EX tracker; `ex_data_in` is valid this cycle.
- `ex_data_in` input `$bits(trace_output)`: trace element, `ryuki_datatypes::trace_output`, stored opaquely.
- `trace_data_o` output `$bits(trace_output)`: head element.
- `trace_valid_o` output 1: head element is valid.
- `trace_ready_i` input 1: sink accepts the head this cycle.
- `level_o` output `$clog2(DEPTH)+1`: current occupancy, 0..DEPTH.
- `full_o` output 1: `level_o == DEPTH`.
- `empty_o` output 1: `level_o == 0`.
- `overflow_o` output 1: sticky; at least one element has been dropped since reset or clear.
- `drop_count_o` output `CNT_WIDTH`: number of dropped elements, saturating.
- `clear_i` input 1: synchronous clear of `overflow_o` and `drop_count_o` only.

## Operation
- Storage is a circular array of DEPTH entries with a write pointer `wr_ptr`, a read pointer `rd_ptr` and a count register.
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally from DEPTH-1 to 0.
  - The count is kept separately so that full and empty are unambiguous.
- The array is not reset. Pointers, count, `overflow_o` and `drop_count_o` are reset.
- pop = `trace_valid_o && trace_ready_i`.
- push = `ex_data_ready && (!full_o || pop)`.
  - When the buffer is full, a push in the same cycle as a pop is accepted, because the pop frees the slot.
- drop = `ex_data_ready && full_o && !pop`.
  - The element is discarded.
  - `overflow_o` is set.
  - `drop_count_o` increments, saturating at 2^CNT_WIDTH−1.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Output data and flags:
  - `trace_data_o = mem[rd_ptr]`, show-ahead.
  - `trace_valid_o = !empty_o`.
  - `trace_data_o` is don't-care while `trace_valid_o` is low.
- There is no bypass path: an element pushed into an empty buffer cannot be popped in the cycle it is pushed.
- `clear_i` interactions:
  - Clear and drop in the same cycle: the count becomes 1 and `overflow_o` stays 1, so the new loss is never hidden.
  - Clear alone: the count becomes 0 and `overflow_o` becomes 0.
- Sink handshake rules:
  - The sink may hold `trace_ready_i` high continuously.
  - `trace_data_o` and `trace_valid_o` stay stable while `trace_valid_o && !trace_ready_i`.
- Reset values:
  - `trace_valid_o` = 0, `level_o` = 0, `full_o` = 0, `empty_o` = 1, `overflow_o` = 0, `drop_count_o` = 0.
- Reset mid-operation discards all buffered elements:
  - the pointers return to 0;
  - any push, pop or clear in the reset cycle is ignored;
  - a strobe during reset is neither stored nor counted as a drop.

## Timing
- Push to visibility, empty buffer: strobe in cycle N, then `trace_valid_o` = 1 and `trace_data_o` = the element in cycle N+1.
- Pop: the head advances at the clock edge ending the pop cycle. The next element, if any, is presented in the following cycle.
- `level_o`, `full_o`, `empty_o`, `overflow_o` and `drop_count_o` are all registered or derived from registers. Each reflects an event one cycle after it occurs.
- Sustained throughput: one push and one pop per cycle with no bubbles, once the buffer holds at least one element.
- The first `ex_data_ready` after reset deassertion is accepted normally.

## Test plan
Benches use DEPTH=4 unless stated otherwise.
1. **Reset:** assert `rst` for 2 cycles with strobes active. Required: after release, `level_o`=0, `empty_o`=1, `trace_valid_o`=0, `drop_count_o`=0, and no element is stored.
2. **Ordering and wrap:** push A,B,C,D with `trace_ready_i`=0. Required: `full_o`=1, `level_o`=4. Then pop 2, push E,F, pop 4. Required: pop order A,B,C,D,E,F, `empty_o`=1 at the end, pointers wrapped.
3. **Overflow:** fill to 4 and strobe 3 more times with no pop. Required: `drop_count_o`=3, `overflow_o`=1, and the contents remain A..D.
4. **Simultaneous push and pop when full:** with the buffer full and `trace_ready_i`=1, strobe G. Required: G accepted, `level_o` stays 4, `drop_count_o` unchanged, G is popped last.
5. **Clear:** pulse `clear_i` alone, which must zero the counter and the flag. Then pulse `clear_i` in the same cycle as a drop. Required: `drop_count_o`=1, `overflow_o`=1.
6. **Saturation:** with CNT_WIDTH=4, drop 20 times. Required: `drop_count_o`=15, no wrap. Also back-to-back streaming at 1/cycle: 100 elements, 0 drops, in-order.
